wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register bank's single write port between NUM_REQ completing functional units (ALU, load, mul/div, ...).
- Round-robin arbitration with a registered write stage; drives the bank's write_address/write_data directly.
- The bank writes every cycle with no write enable, so idle cycles drive address 0, which is a harmless x0 write.
- Requests targeting x0 are absorbed without consuming the port.

Parameters:
- NUM_REQ, 4, number of requesting units (2..8).
- DWIDTH, 32, data width.
- AWIDTH, 5, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a result.
- req_addr  in  NUM_REQ x AWIDTH  destination register per requester.
- req_data  in  NUM_REQ x DWIDTH  result data per requester.
- req_ready  out  NUM_REQ  requester i's result is accepted this cycle (combinational).
- flush  in  1  pipeline squash.
- write_address  out  AWIDTH  to bank write port (registered).
- write_data  out  DWIDTH  to bank write port (registered).
- grant_id  out  clog2(NUM_REQ)  index of the requester owning the current write_address/write_data (registered).
- wb_active  out  1  write_address/write_data carry a real write this cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - write_address=0, write_data=0, grant_id=0, wb_active=0.
  - RR pointer=0; req_ready=0 while reset is low.
- Eligibility: requester i is eligible when req_valid[i]=1 and req_addr[i]!=0.
- Zero-address requests: req_valid[i]=1 with req_addr[i]=0 gets req_ready[i]=1 in the same cycle, unconditionally (except during flush). It is dropped and never wins the grant.
- Grant:
  - Among eligible requesters, the first at or after the RR pointer (wrapping modulo NUM_REQ) wins; req_ready[winner]=1.
  - All other eligible requesters get req_ready=0 and must hold valid, addr and data stable until accepted.
- Pointer: after a grant the pointer becomes winner+1, wrapping NUM_REQ-1 to 0. With no grant it holds.
- Latency: a result accepted in cycle N appears on write_address/write_data/grant_id in cycle N+1 with wb_active=1. The bank captures it at the end of N+1. Throughput is one write per cycle.
- Idle cycle (no grant): next cycle write_address=0, write_data=0, wb_active=0, grant_id holds.
- flush=1 in cycle N:
  - All req_ready=0 in N.
  - The write stage is loaded with the idle value, so cycle N+1 has address 0 and wb_active=0.
  - A write already on the outputs in cycle N still completes in N; it is not retracted.
  - The pointer holds.
- Reset mid-operation: the output clears immediately (asynchronous). A pending write is lost; requesters re-present after reset.
- No state machine beyond the pointer and the output register. At most one grant plus any number of zero-address acceptances per cycle.

Optional Feature:
- Macro WB_ARB_FIXED_PRIO0_EN.
- Defined: requester 0, the load unit, wins whenever it is eligible, regardless of pointer. A grant to requester 0 does not move the pointer; other requesters rotate round-robin as normal.
- Undefined: pure round-robin across all requesters, including 0.

Decomposition:
- Shared package rv_ooo_pkg holds:
  - REG_AWIDTH=5 and XLEN=32 constants.
  - typedef wb_req_t {valid, addr, data}.
- Natural sub-module: rr_arbiter (NUM_REQ-wide request vector in; one-hot grant plus index out; pointer update input). Reusable for issue-port sharing.

Test Plan:
- Reset low, then release; all valid=0 for 3 cycles -> write_address=0, wb_active=0, req_ready=0 every cycle.
- Single request: req_valid=0001, addr[0]=5, data[0]=0xDEADBEEF in cycle 2 -> req_ready=0001 in cycle 2; cycle 3 write_address=5, write_data=0xDEADBEEF, grant_id=0, wb_active=1; cycle 4 write_address=0.
- All four valid, addrs 1/2/3/4, held until accepted, pointer=0 -> grants 0,1,2,3 on consecutive cycles; write_address sequence 1,2,3,4, then 0.
- req_valid=0011 with addr[0]=0, addr[1]=7 -> both ready in the same cycle; next cycle write_address=7, grant_id=1; pointer advances to 2.
- Requester 2 granted in cycle N, flush=1 in cycle N+1 while requester 3 is valid:
  - cycle N+1 write_address carries requester 2's write;
  - req_ready=0 in N+1;
  - cycle N+2 write_address=0, wb_active=0;
  - requester 3 is granted in N+2.
- With WB_ARB_FIXED_PRIO0_EN, requesters 0 and 1 held valid for 3 cycles -> 0,0,0 granted, then 1. Without the macro -> 0,1,0,1.

Source files
------------

// File: rtl/rv_ooo_pkg.sv
// Shared definitions for the out-of-order core's register-file plumbing:
// architectural widths, the write-back request record and round-robin helpers.
package rv_ooo_pkg;

    localparam int REG_AWIDTH = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_AWIDTH-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Successor of a requester index on the ring 0..n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first request at or after the pointer wins; the
// pointer moves past the winner only when the caller asks for it.
module rr_arbiter
    import rv_ooo_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           grant_any
);

    logic [IDW-1:0] ptr_q, ptr_d;

    // Scan from farthest to nearest so the request closest to the pointer wins.
    always_comb begin : select
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr_q) + off) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_any) begin
            ptr_d = IDW'(rr_next(int'(grant_idx), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register bank's single write port among NUM_REQ units with a
// registered write stage. Define WB_ARB_FIXED_PRIO0_EN to give requester 0 fixed priority.
module wb_port_arbiter
    import rv_ooo_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DWIDTH  = XLEN,
    parameter  int AWIDTH  = REG_AWIDTH,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][AWIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DWIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            flush,
    output logic [AWIDTH-1:0]               write_address,
    output logic [DWIDTH-1:0]               write_data,
    output logic [IDW-1:0]                  grant_id,
    output logic                            wb_active
);

    logic [NUM_REQ-1:0] elig, zero_ack;
    logic [NUM_REQ-1:0] rr_grant, win_vec;
    logic [IDW-1:0]     rr_idx, win_idx;
    logic               rr_any, win_any, prio0;

    logic [AWIDTH-1:0]  write_address_q, write_address_d;
    logic [DWIDTH-1:0]  write_data_q, write_data_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               wb_active_q, wb_active_d;

    // x0 writes are architecturally void, so they are acknowledged without a grant.
    always_comb begin
        elig     = '0;
        zero_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]     = req_valid[i] && (req_addr[i] != '0);
            zero_ack[i] = req_valid[i] && (req_addr[i] == '0);
        end
    end

`ifdef WB_ARB_FIXED_PRIO0_EN
    assign prio0 = elig[0];
`else
    assign prio0 = 1'b0;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (reset),
        .req       (elig),
        .advance   (!flush && !prio0),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .grant_any (rr_any)
    );

    always_comb begin
        win_any = prio0 || rr_any;
        win_idx = prio0 ? '0 : rr_idx;
        win_vec = prio0 ? NUM_REQ'(1) : rr_grant;
    end

    assign req_ready = (reset && !flush) ? (zero_ack | win_vec) : '0;

    // Write stage: idle and flushed cycles load the harmless x0 write.
    always_comb begin
        write_address_d = '0;
        write_data_d    = '0;
        wb_active_d     = 1'b0;
        grant_id_d      = grant_id_q;
        if (win_any && !flush) begin
            write_address_d = req_addr[win_idx];
            write_data_d    = req_data[win_idx];
            wb_active_d     = 1'b1;
            grant_id_d      = win_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_address_q <= '0;
            write_data_q    <= '0;
            grant_id_q      <= '0;
            wb_active_q     <= 1'b0;
        end else begin
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            grant_id_q      <= grant_id_d;
            wb_active_q     <= wb_active_d;
        end
    end

    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign grant_id      = grant_id_q;
    assign wb_active     = wb_active_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// all compared against a ring-distance reference model.
module tb_wb_port_arbiter;

    localparam int N   = 4;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int IDW = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 flush = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0][AW-1:0] req_addr = '0;
    logic [N-1:0][DW-1:0] req_data = '0;
    logic [N-1:0]         req_ready;
    logic [AW-1:0]        write_address;
    logic [DW-1:0]        write_data;
    logic [IDW-1:0]       grant_id;
    logic                 wb_active;

    int vectors = 0;
    int miscompares = 0;

    int            m_ptr;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            m_gid;
    logic          m_act;
    logic [N-1:0]  obs_rdy;
    logic [N-1:0]  last_rdy;

    always #5 clk = ~clk;

    wb_port_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .flush         (flush),
        .write_address (write_address),
        .write_data    (write_data),
        .grant_id      (grant_id),
        .wb_active     (wb_active)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_wa     = '0;
        m_wd     = '0;
        m_gid    = 0;
        m_act    = 1'b0;
        last_rdy = '0;
    endtask

    // Winner = eligible requester with the smallest ring distance from the pointer.
    function automatic int pick();
        int best;
        int bestd;
        best  = -1;
        bestd = N;
`ifdef WB_ARB_FIXED_PRIO0_EN
        if (req_valid[0] && req_addr[0] != '0) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_addr[i] != '0) begin
                int d;
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // One clock cycle: inputs already applied; checks at the falling edge,
    // returns 1 time unit after the next rising edge.
    task automatic step();
        int           win;
        logic [N-1:0] er;
        win = pick();
        er  = '0;
        if (!flush) begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_addr[i] == '0) er[i] = 1'b1;
            if (win >= 0) er[win] = 1'b1;
        end
        @(negedge clk);
        obs_rdy = req_ready;
        check("req_ready", 64'(req_ready), 64'(er));
        check("write_address", 64'(write_address), 64'(m_wa));
        check("write_data", 64'(write_data), 64'(m_wd));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("wb_active", 64'(wb_active), 64'(m_act));
        if (win >= 0 && !flush) begin
            m_wa  = req_addr[win];
            m_wd  = req_data[win];
            m_gid = win;
            m_act = 1'b1;
`ifdef WB_ARB_FIXED_PRIO0_EN
            if (win != 0) m_ptr = (win + 1) % N;
`else
            m_ptr = (win + 1) % N;
`endif
        end else begin
            m_wa  = '0;
            m_wd  = '0;
            m_act = 1'b0;
        end
        last_rdy = er;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < N; i++)
            if (last_rdy[i]) req_valid[i] = 1'b0;
    endtask

    initial begin
        int a4_seq[5];
        int prio_seq[4];
        a4_seq = '{1, 2, 3, 4, 0};
`ifdef WB_ARB_FIXED_PRIO0_EN
        prio_seq = '{0, 0, 0, 1};
`else
        prio_seq = '{0, 1, 0, 1};
`endif
        model_reset();

        // Reset held with requests present: no acceptance, outputs cleared.
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_addr[i] = AW'(i + 1);
        #12;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_waddr", 64'(write_address), 64'(0));
        check("rst_wdata", 64'(write_data), 64'(0));
        check("rst_gid", 64'(grant_id), 64'(0));
        check("rst_active", 64'(wb_active), 64'(0));
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        repeat (3) step();
        check("idle_waddr", 64'(write_address), 64'(0));

        // All four requesters held until accepted.
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = AW'(i + 1);
            req_data[i] = 32'h1000 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 4) check("a4_ready", 64'(obs_rdy), 64'(1 << k));
            check("a4_waddr", 64'(write_address), 64'(a4_seq[k]));
            drop_accepted();
        end

        // Single request.
        req_valid   = 4'b0001;
        req_addr[0] = 5'd5;
        req_data[0] = 32'hDEADBEEF;
        step();
        check("single_ready", 64'(obs_rdy), 64'(4'b0001));
        drop_accepted();
        check("single_waddr", 64'(write_address), 64'(5));
        check("single_wdata", 64'(write_data), 64'(32'hDEADBEEF));
        check("single_gid", 64'(grant_id), 64'(0));
        check("single_active", 64'(wb_active), 64'(1));
        step();
        check("single_idle", 64'(write_address), 64'(0));

        // x0 request absorbed alongside a real grant.
        req_valid   = 4'b0011;
        req_addr[0] = 5'd0;
        req_addr[1] = 5'd7;
        req_data[1] = 32'h77;
        step();
        check("x0_ready", 64'(obs_rdy), 64'(4'b0011));
        drop_accepted();
        check("x0_waddr", 64'(write_address), 64'(7));
        check("x0_gid", 64'(grant_id), 64'(1));

        // Flush right after a grant to requester 2.
        req_valid   = 4'b0100;
        req_addr[2] = 5'd9;
        req_data[2] = 32'h99;
        step();
        check("fl_grant2", 64'(obs_rdy), 64'(4'b0100));
        drop_accepted();
        req_valid   = 4'b1000;
        req_addr[3] = 5'd11;
        req_data[3] = 32'hBB;
        flush       = 1'b1;
        check("fl_inflight", 64'(write_address), 64'(9));
        step();
        check("fl_ready", 64'(obs_rdy), 64'(0));
        check("fl_waddr", 64'(write_address), 64'(0));
        check("fl_active", 64'(wb_active), 64'(0));
        flush = 1'b0;
        step();
        check("fl_grant3", 64'(obs_rdy), 64'(4'b1000));
        drop_accepted();
        check("fl_waddr3", 64'(write_address), 64'(11));
        check("fl_gid3", 64'(grant_id), 64'(3));

        // Requesters 0 and 1 both presenting for three cycles, then 1 alone.
        req_addr[0] = 5'd3;
        req_addr[1] = 5'd6;
        for (int c = 0; c < 4; c++) begin
            req_valid   = (c < 3) ? 4'b0011 : 4'b0010;
            req_data[0] = 32'h200 + 32'(c);
            req_data[1] = 32'h300 + 32'(c);
            step();
            check("prio_gid", 64'(grant_id), 64'(prio_seq[c]));
        end
        req_valid = '0;
        step();

        // Random traffic with flushes and one mid-run reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_rdy[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i]  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
                    req_data[i]  = $urandom;
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            if (c == 200) begin
                req_valid = 4'b1111;
                reset     = 1'b0;
                #2;
                check("mid_rst_ready", 64'(req_ready), 64'(0));
                check("mid_rst_waddr", 64'(write_address), 64'(0));
                check("mid_rst_active", 64'(wb_active), 64'(0));
                check("mid_rst_gid", 64'(grant_id), 64'(0));
                model_reset();
                req_valid = '0;
                flush     = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
